// File: rtl/product_accumulator.sv
// Signed dot-product accumulator fed by a sequential multiplier: one term per rising edge of
// prod_ready, TERMS terms per result, guard bits so the running sum never wraps.
module product_accumulator #(
    parameter int unsigned NB    = 8,
    parameter int unsigned TERMS = 4,
    parameter int unsigned GB    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          prod_ready,
    input  logic signed [2*NB-1:0]        product,
    input  logic                          clear,
    output logic signed [2*NB+GB-1:0]     sum,
    output logic                          sum_valid,
    output logic [$clog2(TERMS)-1:0]      count,
    output logic                          busy
);

    localparam int unsigned SW = 2 * NB + GB;
    localparam int unsigned CW = $clog2(TERMS);

    typedef enum logic {StIdle, StAccum} state_e;

    state_e               state_q, state_d;
    logic                 rdy_q, rdy_d;
    logic signed [SW-1:0] acc_q, acc_d;
    logic signed [SW-1:0] sum_q, sum_d;
    logic                 sum_valid_q, sum_valid_d;
    logic [CW-1:0]        count_q, count_d;

    logic                 accept;
    logic                 last_term;
    logic signed [SW-1:0] prod_ext;

    assign accept    = prod_ready & ~rdy_q;
    assign last_term = (count_q == CW'(TERMS - 1));
    assign prod_ext  = {{GB{product[2*NB-1]}}, product};

    // Datapath next-state: clear discards the old partial sum but still takes a coincident term.
    always_comb begin
        rdy_d       = prod_ready;
        acc_d       = acc_q;
        count_d     = count_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        if (clear) begin
            acc_d   = '0;
            count_d = '0;
            if (accept) begin
                acc_d   = prod_ext;
                count_d = CW'(1);
            end
        end else if (accept) begin
            if (last_term) begin
                sum_d       = acc_q + prod_ext;
                sum_valid_d = 1'b1;
                acc_d       = '0;
                count_d     = '0;
            end else begin
                acc_d   = acc_q + prod_ext;
                count_d = count_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (clear && !accept) begin
                    state_d = StIdle;
                end else if (!clear && accept && last_term) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // rdy_q resets high so a multiplier already idling with ready asserted is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rdy_q       <= 1'b1;
            acc_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        busy      = (state_q == StAccum);
        count     = count_q;
        sum       = sum_q;
        sum_valid = sum_valid_q;
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Signed accumulation stage directly downstream of the sequential signed multiplier (`multiplier4`). Captures each completed `Product` when the multiplier's `ready` rises, sums a fixed number of consecutive products with guard bits, and emits the dot-product result with a one-cycle valid pulse. Together with the multiplier it forms a multiply-accumulate path for fixed-length signed dot products.

## Interface
- `NB`, 8: multiplier operand width; product width is 2*NB.
- `TERMS`, 4: products summed per result; must be at least 2.
- `GB`, 2: guard bits; must be at least ceil(log2(TERMS)).
- `clk` input, 1 bit: single clock; all logic is on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `prod_ready` input, 1 bit: multiplier `ready`, connected directly.
- `product` input, 2*NB bits, signed: multiplier `Product`.
- `clear` input, 1 bit: synchronous abort of the partial sum.
- `sum` output, 2*NB+GB bits, signed: last completed result; held until the next result.
- `sum_valid` output, 1 bit: one-cycle pulse when `sum` updates.
- `count` output, ceil(log2(TERMS)) bits: terms accepted in the current accumulation.
- `busy` output, 1 bit: high when `count` is not 0.

## Operation
- Edge detect:
  - register `rdy_q` samples `prod_ready` every cycle.
  - A product is accepted in any cycle where `prod_ready`=1 and `rdy_q`=0, i.e. once per completed multiplication.
  - This works whether `ready` is a level or a pulse.
- Sign extension: `product` is sign-extended to 2*NB+GB bits before the add. No saturation is needed; the guard bits guarantee no overflow.
- Accept with `count` < TERMS-1:
  - `acc` <= `acc` + ext(`product`)
  - `count` <= `count`+1
- Accept with `count` = TERMS-1 (final term):
  - `sum` <= `acc` + ext(`product`)
  - `sum_valid` <= 1
  - `acc` <= 0, `count` <= 0
- States:
  - IDLE: `count`=0.
  - ACCUM: 0 < `count` < TERMS.
  - Transitions happen only on accepted products, `clear`, or `rst`.
- `clear` without accept: `acc` <= 0, `count` <= 0. `sum` is unchanged and there is no pulse.
- `clear` and accept in the same cycle: `clear` has priority for the old partial sum. The new product becomes term 0: `acc` <= ext(`product`), `count` <= 1. No result is emitted even if `count` was TERMS-1.
- `rst`:
  - `acc`=0, `count`=0, `sum`=0, `sum_valid`=0.
  - `rdy_q`=1, so a multiplier idling with `ready` high after reset is not counted.
  - `rst` takes priority over `clear` and over accept.
- Reset mid-accumulation discards the partial sum. The next accepted product is term 0.
- `product` is sampled only in the accept cycle; its value at other times is don't-care, including X.

## Timing
- Accept latency: `acc` and `count` update at the clock edge that samples the rising `prod_ready`.
- Result latency: `sum` and `sum_valid` are visible one cycle after `prod_ready` rises for the last term.
- `sum_valid` is high for exactly one cycle per result.
- Throughput: one product per `prod_ready` rising edge. Back-to-back edges two cycles apart (1,0,1) are both accepted.
- `prod_ready` held high for many cycles counts once.
- `busy` and `count` are registered with no combinational path from inputs.
- Reset values: `sum`=0, `sum_valid`=0, `count`=0, `busy`=0.

## Test plan
All scenarios use NB=8, TERMS=4, GB=2.
- Basic sum: products 100, -200, 3000, -5, each presented with a `ready` 0→1 edge → one `sum_valid` pulse with `sum`=2895. `count` steps 1,2,3,0.
- Extreme values: four products of 16384 (-128×-128) → `sum`=65536. Then four of -16256 (-128×127) → `sum`=-65024 as an 18-bit signed value, with no wrap.
- Level ready: `prod_ready` held high for 20 cycles with `product`=7 → exactly one term accepted (`count`=1). Reset with `prod_ready` already high → nothing accepted until `prod_ready` falls and rises.
- Clear: after 3 terms (1,2,3), assert `clear` alone → `count`=0 and `sum` keeps its old value. After 3 terms, assert `clear` together with an accept of 50 → `count`=1, no pulse. Then terms 1,1,1 → `sum`=53.
- Reset mid-operation: 2 terms accepted, then `rst` for 1 cycle → `sum`=0, `count`=0. The next 4 terms (10,20,30,40) give `sum`=100.
- Integration with `multiplier4`: 1000 random operand pairs, issuing `start` each time the previous product completes → each `sum` equals the exact signed sum of the 4 corresponding A×B values.
